// File: rtl/video_timing_gen_if.sv
// Video timing bundle between the raster generator and its consumers.
// The master side is the timing generator; the slave side is the mixer/scaler.
interface video_timing_gen_if #(
    parameter int CNT_W = 9,
    parameter int RGB_W = 12
);
    logic                    PCLK_EN;
    logic                    MODE;
    logic signed [3:0]       HOFFS;
    logic signed [3:0]       VOFFS;
    logic [RGB_W-1:0]        iRGB;
    logic [CNT_W-1:0]        HPOS;
    logic [CNT_W-1:0]        VPOS;
    logic [RGB_W-1:0]        oRGB;
    logic                    HBLK;
    logic                    VBLK;
    logic                    HSYN;
    logic                    VSYN;
    logic                    DE;
    logic                    LINE_START;
    logic                    FRAME_START;
    logic [7:0]              FRAME_CNT;

    modport master (
        input  PCLK_EN, MODE, HOFFS, VOFFS, iRGB,
        output HPOS, VPOS, oRGB, HBLK, VBLK, HSYN, VSYN, DE,
               LINE_START, FRAME_START, FRAME_CNT
    );

    modport slave (
        output PCLK_EN, MODE, HOFFS, VOFFS, iRGB,
        input  HPOS, VPOS, oRGB, HBLK, VBLK, HSYN, VSYN, DE,
               LINE_START, FRAME_START, FRAME_CNT
    );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel/line counters, blanking, sync,
// blanked RGB, line/frame strobes and a frame counter. Mode and sync offsets
// are shadowed at the frame boundary so mid-frame changes never tear a frame.
module video_timing_gen #(
    parameter int               CNT_W     = 9,
    parameter int               RGB_W     = 12,
    parameter int               H_TOTAL   = 320,
    parameter int               V_TOTAL   = 260,
    parameter int               V_ACT     = 224,
    parameter int               HB0_S     = 29,
    parameter int               HB0_E     = 285,
    parameter int               HB1_S     = 37,
    parameter int               HB1_E     = 277,
    parameter int               HS_BASE   = 296,
    parameter int               HS_LEN    = 16,
    parameter int               VS_BASE   = 234,
    parameter int               VS_LEN    = 4,
    parameter int               HPOS_BIAS = 16,
    parameter logic [RGB_W-1:0] BORDER    = '0
) (
    input  logic               CLK,
    input  logic               RST_N,
    video_timing_gen_if.master vif
);

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT_C   = CNT_W'(V_ACT);
    localparam logic [CNT_W-1:0] HB0_S_C   = CNT_W'(HB0_S);
    localparam logic [CNT_W-1:0] HB0_E_C   = CNT_W'(HB0_E);
    localparam logic [CNT_W-1:0] HB1_S_C   = CNT_W'(HB1_S);
    localparam logic [CNT_W-1:0] HB1_E_C   = CNT_W'(HB1_E);
    localparam logic [CNT_W-1:0] HS_BASE_C = CNT_W'(HS_BASE);
    localparam logic [CNT_W-1:0] HS_LEN_C  = CNT_W'(HS_LEN);
    localparam logic [CNT_W-1:0] VS_BASE_C = CNT_W'(VS_BASE);
    localparam logic [CNT_W-1:0] VS_LEN_C  = CNT_W'(VS_LEN);
    localparam logic [CNT_W-1:0] BIAS_C    = CNT_W'(HPOS_BIAS);

    // Sign-extend a 4-bit offset to counter width so the add wraps modulo 2^CNT_W.
    function automatic logic [CNT_W-1:0] sext_offs(input logic signed [3:0] offs);
        return {{(CNT_W-4){offs[3]}}, offs};
    endfunction

    // Half-open window test: b <= x < e.
    function automatic logic in_window(input logic [CNT_W-1:0] x,
                                       input logic [CNT_W-1:0] b,
                                       input logic [CNT_W-1:0] e);
        return (x >= b) && (x < e);
    endfunction

    logic [CNT_W-1:0]  hcnt, vcnt;
    logic              mode_sh;
    logic signed [3:0] hoffs_sh, voffs_sh;
    logic [7:0]        frame_cnt;
    logic              h_wrap, f_wrap;
    logic [CNT_W-1:0]  hs_b, hs_e, vs_b, vs_e;
    logic              hb, vb, hs_act, vs_act;
    logic [RGB_W-1:0]  rgb_nxt;

    logic              hblk_p1, vblk_p1, de_p1, hsyn_p1, vsyn_p1;
    logic              line_start_p1, frame_start_p1;
    logic [RGB_W-1:0]  rgb_p1;

    // Decode blanking, sync windows and next pixel from the current counters.
    always_comb begin
        h_wrap  = (hcnt == H_LAST);
        f_wrap  = h_wrap && (vcnt == V_LAST);
        hs_b    = HS_BASE_C + sext_offs(hoffs_sh);
        hs_e    = hs_b + HS_LEN_C;
        vs_b    = VS_BASE_C + sext_offs(voffs_sh);
        vs_e    = vs_b + VS_LEN_C;
        hb      = mode_sh ? !in_window(hcnt, HB1_S_C, HB1_E_C)
                          : !in_window(hcnt, HB0_S_C, HB0_E_C);
        vb      = (vcnt >= V_ACT_C);
        hs_act  = in_window(hcnt, hs_b, hs_e);
        vs_act  = in_window(vcnt, vs_b, vs_e);
        rgb_nxt = (hb || vb) ? BORDER : vif.iRGB;
    end

    // Raster counters: pixel within line, line within frame.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (vif.PCLK_EN) begin
            if (h_wrap) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + ONE;
            end else begin
                hcnt <= hcnt + ONE;
            end
        end
    end

    // Capture mode/offsets and count frames only at the last pixel of a frame.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mode_sh   <= 1'b0;
            hoffs_sh  <= '0;
            voffs_sh  <= '0;
            frame_cnt <= '0;
        end else if (vif.PCLK_EN && f_wrap) begin
            mode_sh   <= vif.MODE;
            hoffs_sh  <= vif.HOFFS;
            voffs_sh  <= vif.VOFFS;
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    // ---- stage p1: timing outputs registered one pixel behind the counters ----
    // Register blank, sync, strobes and pixel together so they stay aligned.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hblk_p1        <= 1'b1;
            vblk_p1        <= 1'b1;
            de_p1          <= 1'b0;
            hsyn_p1        <= 1'b1;
            vsyn_p1        <= 1'b1;
            line_start_p1  <= 1'b0;
            frame_start_p1 <= 1'b0;
            rgb_p1         <= BORDER;
        end else if (vif.PCLK_EN) begin
            hblk_p1        <= hb;
            vblk_p1        <= vb;
            de_p1          <= !(hb || vb);
            hsyn_p1        <= !hs_act;
            vsyn_p1        <= !vs_act;
            line_start_p1  <= (hcnt == '0);
            frame_start_p1 <= (hcnt == '0) && (vcnt == '0);
            rgb_p1         <= rgb_nxt;
        end
    end

    assign vif.HPOS        = hcnt - BIAS_C;
    assign vif.VPOS        = vcnt;
    assign vif.HBLK        = hblk_p1;
    assign vif.VBLK        = vblk_p1;
    assign vif.DE          = de_p1;
    assign vif.HSYN        = hsyn_p1;
    assign vif.VSYN        = vsyn_p1;
    assign vif.LINE_START  = line_start_p1;
    assign vif.FRAME_START = frame_start_p1;
    assign vif.oRGB        = rgb_p1;
    assign vif.FRAME_CNT   = frame_cnt;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a shrunken raster (64x20) so that
// several complete frames fit in a short run. Geometry mirrors the default
// shape: mode 0 window 5..52 (48 px), mode 1 window 9..48 (40 px),
// HSYNC at 56 (4 px), VSYNC at line 16 (2 lines), 14 active lines.
module tb_video_timing_gen;

    localparam int          HT  = 64;
    localparam int          VT  = 20;
    localparam logic [11:0] BRD = 12'h123;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    video_timing_gen_if #(.CNT_W(9), .RGB_W(12)) vif ();

    video_timing_gen #(
        .CNT_W(9), .RGB_W(12), .H_TOTAL(HT), .V_TOTAL(VT), .V_ACT(14),
        .HB0_S(5), .HB0_E(53), .HB1_S(9), .HB1_E(49),
        .HS_BASE(56), .HS_LEN(4), .VS_BASE(16), .VS_LEN(2),
        .HPOS_BIAS(4), .BORDER(BRD)
    ) dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .vif  (vif)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    int h = 0, v = 0, pre_h = 0, pre_v = 0;
    int fs_cnt, ls_cnt, de_first, de_last, hb_low, hs_first, hs_cnt;
    int vs_first, vs_cnt, de_total, rgb_act, rgb_brd, de_bad, vb_cnt, de_vblank;

    // One clock; bench raster position advances when the pixel enable is high.
    task automatic tick();
        pre_h = h;
        pre_v = v;
        @(posedge clk);
        #1;
        if (vif.PCLK_EN) begin
            if (h == HT - 1) begin
                h = 0;
                v = (v == VT - 1) ? 0 : v + 1;
            end else begin
                h = h + 1;
            end
        end
    endtask

    // Run one full frame from (0,0), optionally changing MODE/offsets at the
    // start of chg_line, and gather statistics on the registered outputs.
    task automatic run_frame(input int probe, input int chg_line, input logic new_mode,
                             input logic [3:0] new_hoffs, input logic [3:0] new_voffs,
                             input logic [11:0] rgb);
        fs_cnt = 0; ls_cnt = 0; de_first = -1; de_last = -1; hb_low = 0;
        hs_first = -1; hs_cnt = 0; vs_first = -1; vs_cnt = 0; de_total = 0;
        rgb_act = 0; rgb_brd = 0; de_bad = 0; vb_cnt = 0; de_vblank = 0;
        vif.iRGB = rgb;
        for (int i = 0; i < HT * VT; i++) begin
            if (v == chg_line && h == 0) begin
                vif.MODE  = new_mode;
                vif.HOFFS = new_hoffs;
                vif.VOFFS = new_voffs;
            end
            tick();
            if (vif.FRAME_START) fs_cnt++;
            if (vif.LINE_START) ls_cnt++;
            if (pre_v == probe) begin
                if (vif.DE) begin
                    if (de_first < 0) de_first = pre_h;
                    de_last = pre_h;
                end
                if (!vif.HBLK) hb_low++;
                if (!vif.HSYN) begin
                    if (hs_first < 0) hs_first = pre_h;
                    hs_cnt++;
                end
            end
            if (!vif.VSYN) begin
                if (vs_first < 0) vs_first = pre_v;
                vs_cnt++;
            end
            if (vif.VBLK) vb_cnt++;
            if (vif.DE) de_total++;
            if (vif.DE && pre_v >= 14) de_vblank++;
            if (vif.DE && vif.oRGB == rgb) rgb_act++;
            if (!vif.DE && vif.oRGB == BRD) rgb_brd++;
            if (vif.DE !== !(vif.HBLK || vif.VBLK)) de_bad++;
        end
    endtask

    task automatic test_reset();
        vif.PCLK_EN = 1'b0; vif.MODE = 1'b0; vif.HOFFS = 4'h0; vif.VOFFS = 4'h0;
        vif.iRGB = 12'hABC;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (vif.HBLK !== 1'b1) $display("FAIL reset_hblk got %b want 1", vif.HBLK); else pass_cnt++;
        total_cnt++; if (vif.VBLK !== 1'b1) $display("FAIL reset_vblk got %b want 1", vif.VBLK); else pass_cnt++;
        total_cnt++; if (vif.HSYN !== 1'b1) $display("FAIL reset_hsyn got %b want 1", vif.HSYN); else pass_cnt++;
        total_cnt++; if (vif.VSYN !== 1'b1) $display("FAIL reset_vsyn got %b want 1", vif.VSYN); else pass_cnt++;
        total_cnt++; if (vif.DE !== 1'b0) $display("FAIL reset_de got %b want 0", vif.DE); else pass_cnt++;
        total_cnt++; if (vif.LINE_START !== 1'b0) $display("FAIL reset_line_start got %b want 0", vif.LINE_START); else pass_cnt++;
        total_cnt++; if (vif.FRAME_START !== 1'b0) $display("FAIL reset_frame_start got %b want 0", vif.FRAME_START); else pass_cnt++;
        total_cnt++; if (vif.oRGB !== BRD) $display("FAIL reset_orgb got %h want %h", vif.oRGB, BRD); else pass_cnt++;
        total_cnt++; if (vif.FRAME_CNT !== 8'd0) $display("FAIL reset_frame_cnt got %0d want 0", vif.FRAME_CNT); else pass_cnt++;
        total_cnt++; if (vif.VPOS !== 9'd0) $display("FAIL reset_vpos got %0d want 0", vif.VPOS); else pass_cnt++;
        total_cnt++; if (vif.HPOS !== 9'd508) $display("FAIL reset_hpos got %0d want 508", vif.HPOS); else pass_cnt++;
        rst_n = 1'b1;
        vif.PCLK_EN = 1'b1;
        h = 0; v = 0;
    endtask

    task automatic test_frame_counter();
        run_frame(0, -1, 1'b0, 4'h0, 4'h0, 12'hABC);
        total_cnt++; if (fs_cnt != 1) $display("FAIL frame_start_count got %0d want 1", fs_cnt); else pass_cnt++;
        total_cnt++; if (ls_cnt != 20) $display("FAIL line_start_count got %0d want 20", ls_cnt); else pass_cnt++;
        total_cnt++; if (vif.FRAME_CNT !== 8'd1) $display("FAIL frame_cnt_1 got %0d want 1", vif.FRAME_CNT); else pass_cnt++;
        total_cnt++; if (vif.VPOS !== 9'd0) $display("FAIL wrap_vpos got %0d want 0", vif.VPOS); else pass_cnt++;
        total_cnt++; if (vif.HPOS !== 9'd508) $display("FAIL wrap_hpos got %0d want 508", vif.HPOS); else pass_cnt++;
        total_cnt++; if (de_first != 5) $display("FAIL mode0_first_de got %0d want 5", de_first); else pass_cnt++;
        total_cnt++; if (de_last != 52) $display("FAIL mode0_last_de got %0d want 52", de_last); else pass_cnt++;
        total_cnt++; if (hb_low != 48) $display("FAIL mode0_hblk_low got %0d want 48", hb_low); else pass_cnt++;
    endtask

    task automatic test_rgb_gating();
        run_frame(0, -1, 1'b0, 4'h0, 4'h0, 12'hABC);
        total_cnt++; if (de_total != 672) $display("FAIL de_total got %0d want 672", de_total); else pass_cnt++;
        total_cnt++; if (rgb_act != 672) $display("FAIL rgb_active got %0d want 672", rgb_act); else pass_cnt++;
        total_cnt++; if (rgb_brd != 608) $display("FAIL rgb_border got %0d want 608", rgb_brd); else pass_cnt++;
        total_cnt++; if (de_bad != 0) $display("FAIL de_vs_blank got %0d want 0", de_bad); else pass_cnt++;
        total_cnt++; if (vb_cnt != 384) $display("FAIL vblk_count got %0d want 384", vb_cnt); else pass_cnt++;
        total_cnt++; if (de_vblank != 0) $display("FAIL de_in_vblank got %0d want 0", de_vblank); else pass_cnt++;
        total_cnt++; if (hs_first != 56) $display("FAIL hsync_start got %0d want 56", hs_first); else pass_cnt++;
        total_cnt++; if (hs_cnt != 4) $display("FAIL hsync_width got %0d want 4", hs_cnt); else pass_cnt++;
        total_cnt++; if (vs_first != 16) $display("FAIL vsync_start got %0d want 16", vs_first); else pass_cnt++;
        total_cnt++; if (vs_cnt != 128) $display("FAIL vsync_pixels got %0d want 128", vs_cnt); else pass_cnt++;
        total_cnt++; if (vif.FRAME_CNT !== 8'd2) $display("FAIL frame_cnt_2 got %0d want 2", vif.FRAME_CNT); else pass_cnt++;
    endtask

    task automatic test_midframe_change();
        run_frame(12, 10, 1'b1, 4'hD, 4'h2, 12'h5A5);
        total_cnt++; if (de_first != 5) $display("FAIL hold_first_de got %0d want 5", de_first); else pass_cnt++;
        total_cnt++; if (hb_low != 48) $display("FAIL hold_hblk_low got %0d want 48", hb_low); else pass_cnt++;
        total_cnt++; if (hs_first != 56) $display("FAIL hold_hsync_start got %0d want 56", hs_first); else pass_cnt++;
        total_cnt++; if (vs_first != 16) $display("FAIL hold_vsync_start got %0d want 16", vs_first); else pass_cnt++;
        total_cnt++; if (rgb_act != 672) $display("FAIL hold_rgb_active got %0d want 672", rgb_act); else pass_cnt++;
        total_cnt++; if (vif.FRAME_CNT !== 8'd3) $display("FAIL frame_cnt_3 got %0d want 3", vif.FRAME_CNT); else pass_cnt++;
    endtask

    task automatic test_new_settings();
        run_frame(3, -1, 1'b1, 4'hD, 4'h2, 12'hABC);
        total_cnt++; if (fs_cnt != 1) $display("FAIL new_frame_start got %0d want 1", fs_cnt); else pass_cnt++;
        total_cnt++; if (de_first != 9) $display("FAIL mode1_first_de got %0d want 9", de_first); else pass_cnt++;
        total_cnt++; if (de_last != 48) $display("FAIL mode1_last_de got %0d want 48", de_last); else pass_cnt++;
        total_cnt++; if (hb_low != 40) $display("FAIL mode1_hblk_low got %0d want 40", hb_low); else pass_cnt++;
        total_cnt++; if (de_total != 560) $display("FAIL mode1_de_total got %0d want 560", de_total); else pass_cnt++;
        total_cnt++; if (hs_first != 53) $display("FAIL hoffs_start got %0d want 53", hs_first); else pass_cnt++;
        total_cnt++; if (hs_cnt != 4) $display("FAIL hoffs_width got %0d want 4", hs_cnt); else pass_cnt++;
        total_cnt++; if (vs_first != 18) $display("FAIL voffs_start got %0d want 18", vs_first); else pass_cnt++;
        total_cnt++; if (vs_cnt != 128) $display("FAIL voffs_pixels got %0d want 128", vs_cnt); else pass_cnt++;
        total_cnt++; if (vif.FRAME_CNT !== 8'd4) $display("FAIL frame_cnt_4 got %0d want 4", vif.FRAME_CNT); else pass_cnt++;
    endtask

    task automatic test_pclk_gate();
        repeat (2 * HT + 1) tick();
        total_cnt++; if (vif.LINE_START !== 1'b1) $display("FAIL gate_line_start_pre got %b want 1", vif.LINE_START); else pass_cnt++;
        vif.PCLK_EN = 1'b0;
        repeat (5) tick();
        total_cnt++; if (vif.LINE_START !== 1'b1) $display("FAIL gate_line_start_hold got %b want 1", vif.LINE_START); else pass_cnt++;
        total_cnt++; if (vif.HPOS !== 9'd509) $display("FAIL gate_hpos_hold got %0d want 509", vif.HPOS); else pass_cnt++;
        total_cnt++; if (vif.VPOS !== 9'd2) $display("FAIL gate_vpos_hold got %0d want 2", vif.VPOS); else pass_cnt++;
        vif.PCLK_EN = 1'b1;
        repeat (19) tick();
        total_cnt++; if (vif.HPOS !== 9'd16) $display("FAIL gate_hpos_resume got %0d want 16", vif.HPOS); else pass_cnt++;
        total_cnt++; if (vif.DE !== 1'b1) $display("FAIL gate_de_resume got %b want 1", vif.DE); else pass_cnt++;
        total_cnt++; if (vif.LINE_START !== 1'b0) $display("FAIL gate_line_start_low got %b want 0", vif.LINE_START); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        int first_de, first_hs;
        vif.PCLK_EN = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if (vif.DE !== 1'b0) $display("FAIL async_de got %b want 0", vif.DE); else pass_cnt++;
        total_cnt++; if (vif.VBLK !== 1'b1) $display("FAIL async_vblk got %b want 1", vif.VBLK); else pass_cnt++;
        total_cnt++; if (vif.HBLK !== 1'b1) $display("FAIL async_hblk got %b want 1", vif.HBLK); else pass_cnt++;
        total_cnt++; if (vif.oRGB !== BRD) $display("FAIL async_orgb got %h want %h", vif.oRGB, BRD); else pass_cnt++;
        total_cnt++; if (vif.FRAME_CNT !== 8'd0) $display("FAIL async_frame_cnt got %0d want 0", vif.FRAME_CNT); else pass_cnt++;
        total_cnt++; if (vif.HPOS !== 9'd508) $display("FAIL async_hpos got %0d want 508", vif.HPOS); else pass_cnt++;
        total_cnt++; if (vif.VPOS !== 9'd0) $display("FAIL async_vpos got %0d want 0", vif.VPOS); else pass_cnt++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        vif.PCLK_EN = 1'b1;
        h = 0; v = 0;
        tick();
        total_cnt++; if (vif.FRAME_START !== 1'b1) $display("FAIL restart_frame_start got %b want 1", vif.FRAME_START); else pass_cnt++;
        total_cnt++; if (vif.LINE_START !== 1'b1) $display("FAIL restart_line_start got %b want 1", vif.LINE_START); else pass_cnt++;
        total_cnt++; if (vif.HPOS !== 9'd509) $display("FAIL restart_hpos got %0d want 509", vif.HPOS); else pass_cnt++;
        first_de = -1;
        first_hs = -1;
        for (int i = 1; i < HT; i++) begin
            tick();
            if (vif.DE && first_de < 0) first_de = pre_h;
            if (!vif.HSYN && first_hs < 0) first_hs = pre_h;
        end
        total_cnt++; if (first_de != 5) $display("FAIL restart_mode_first_de got %0d want 5", first_de); else pass_cnt++;
        total_cnt++; if (first_hs != 56) $display("FAIL restart_hsync_start got %0d want 56", first_hs); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_frame_counter();
        test_rgb_gating();
        test_midframe_change();
        test_new_settings();
        test_pclk_gate();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
